// File: rtl/operand_pair_pkg.sv
// Shared types for the operand pair buffer: slot state and the shift-range helper.
package operand_pair_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // True when a shift amount cannot be meaningfully applied to a word of width w.
    function automatic logic shamt_oob(input logic [63:0] amt, input logic [63:0] w);
        return amt >= w;
    endfunction

endpackage

// File: rtl/operand_slot.sv
// One-entry elastic slot: holds a single token until drained. A drain and a refill
// can happen in the same cycle.
module operand_slot
    import operand_pair_pkg::*;
#(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] in,
    input  logic                 in_valid,
    input  logic                 drain,
    output logic                 in_ready,
    output logic [DATA_TYPE-1:0] out,
    output logic                 full
);

    slot_state_e          state_q, state_d;
    logic [DATA_TYPE-1:0] data_q, data_d;
    logic                 load;

    assign in_ready = (state_q == SLOT_EMPTY) || drain;
    assign load     = in_valid && in_ready;
    assign out      = data_q;
    assign full     = (state_q == SLOT_FULL);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = in;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/operand_pair_buffer.sv
// Joins independent lhs/rhs tokens into one valid pair for the shifter.
// Define OPB_SHIFT_RANGE_CHECK_EN to add outs_oob (rhs >= DATA_TYPE, held with the pair).
module operand_pair_buffer
    import operand_pair_pkg::*;
#(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    output logic [DATA_TYPE-1:0] outs_lhs,
    output logic [DATA_TYPE-1:0] outs_rhs,
    output logic                 outs_valid,
    input  logic                 outs_ready
`ifdef OPB_SHIFT_RANGE_CHECK_EN
    ,
    output logic                 outs_oob
`endif
);

    logic l_full, r_full, xfer_out;

    // Both slots drain together, so a pair is never split across two outputs.
    assign outs_valid = l_full && r_full;
    assign xfer_out   = outs_valid && outs_ready;

    operand_slot #(.DATA_TYPE(DATA_TYPE)) u_slot_l (
        .clk      (clk),
        .rst      (rst),
        .in       (lhs),
        .in_valid (lhs_valid),
        .drain    (xfer_out),
        .in_ready (lhs_ready),
        .out      (outs_lhs),
        .full     (l_full)
    );

    operand_slot #(.DATA_TYPE(DATA_TYPE)) u_slot_r (
        .clk      (clk),
        .rst      (rst),
        .in       (rhs),
        .in_valid (rhs_valid),
        .drain    (xfer_out),
        .in_ready (rhs_ready),
        .out      (outs_rhs),
        .full     (r_full)
    );

`ifdef OPB_SHIFT_RANGE_CHECK_EN
    logic oob_q, oob_d;

    always_comb begin
        oob_d = oob_q;
        if (rhs_valid && rhs_ready)
            oob_d = shamt_oob(64'(rhs), 64'(DATA_TYPE));
    end

    always_ff @(posedge clk) begin
        if (!rst) oob_q <= 1'b0;
        else      oob_q <= oob_d;
    end

    assign outs_oob = oob_q;
`endif

endmodule

// File: doc/operand_pair_buffer.md
Name: operand_pair_buffer

Overview:
- Elastic stage directly upstream of the left-shift unit.
- Captures the lhs (data) and rhs (shift-amount) tokens independently, each into its own one-entry slot. Presents them as one synchronised pair with a single valid.
- Decouples the two producers: an early-arriving operand is registered and stops stalling its producer. The shifter then always sees both operands valid together.
- Sustains full throughput, one pair per cycle.

Parameters:
- DATA_TYPE, 32, bit width of lhs, rhs and both outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk; low = reset.
- lhs  in  DATA_TYPE  data operand.
- lhs_valid  in  1  lhs token present.
- lhs_ready  out  1  lhs slot can accept this cycle.
- rhs  in  DATA_TYPE  shift-amount operand.
- rhs_valid  in  1  rhs token present.
- rhs_ready  out  1  rhs slot can accept this cycle.
- outs_lhs  out  DATA_TYPE  registered lhs of the current pair.
- outs_rhs  out  DATA_TYPE  registered rhs of the current pair.
- outs_valid  out  1  pair available; drives both lhs_valid and rhs_valid of the shifter.
- outs_ready  in  1  consumer accepts the pair (the shifter's joined ready).

Behaviour:
- Single clock domain. Reset is synchronous, active-low, on port rst.
- Per-slot states: EMPTY and FULL. Each slot holds a data register plus its state; there are two slots, L and R.
- Output transfer: xfer_out = outs_valid && outs_ready.
- Output valid: outs_valid = (L==FULL) && (R==FULL). It is purely a function of registered state, with no combinational path from lhs_valid or rhs_valid.
- Input ready:
  - lhs_ready = (L==EMPTY) || xfer_out.
  - rhs_ready = (R==EMPTY) || xfer_out.
  - The combinational outs_ready -> *_ready path is intentional and gives full throughput.
- Input accept:
  - lhs is loaded when lhs_valid && lhs_ready; rhs likewise.
  - On load, the slot data register captures the input and the slot goes, or stays, FULL.
- Transitions for slot L (R is symmetric):
  - EMPTY & load -> FULL.
  - FULL & xfer_out & load -> FULL, with new data.
  - FULL & xfer_out & !load -> EMPTY.
  - FULL & !xfer_out -> FULL, data held.
- Latency: 1 cycle from the later of the two input handshakes to outs_valid.
- Throughput: 1 pair per cycle when both producers and the consumer stream continuously.
- Asymmetric arrival:
  - If L is FULL and R is EMPTY, lhs_ready=0 until the pair drains.
  - Meanwhile rhs_ready=1.
  - No token is ever dropped or duplicated.
- While outs_valid=1 and outs_ready=0, outs_lhs, outs_rhs and outs_valid stay stable (elastic hold rule).
- Width rules:
  - Data passes through unmodified.
  - An rhs value >= DATA_TYPE is forwarded unchanged; its range is the consumer's concern.
- Reset values:
  - Both slots EMPTY; outs_valid=0; lhs_ready=1; rhs_ready=1.
  - outs_lhs=0; outs_rhs=0.
- Reset mid-operation: held tokens are discarded. With rst low, lhs_valid and rhs_valid are ignored and no load occurs that cycle.

Optional Feature:
- Macro: OPB_SHIFT_RANGE_CHECK_EN.
- Defined:
  - Adds output port outs_oob (1 bit) and a per-pair flag register.
  - The flag is captured at rhs load as (rhs >= DATA_TYPE) and held with the R slot.
  - outs_oob is valid only while outs_valid=1. Reset value 0.
- Not defined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (operand_pair_pkg): slot state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module operand_slot:
  - Parameter: DATA_TYPE.
  - Inputs: clk, rst, in, in_valid, drain.
  - Outputs: in_ready, out, full.
  - Instantiated twice, for L and R. The top computes outs_valid and drain = xfer_out.

Test Plan:
- Reset: hold rst=0 for 2 cycles with lhs_valid=rhs_valid=1 -> outs_valid=0, lhs_ready=rhs_ready=1, outs_lhs=outs_rhs=0; no load occurs.
- Simultaneous arrival: lhs=0x5, rhs=0x3, both valid in cycle 0, outs_ready=1 -> cycle 1 outs_valid=1, outs_lhs=0x5, outs_rhs=0x3; pair consumed in cycle 1.
- Skewed arrival: lhs=0xA at cycle 0, rhs=0x2 at cycle 4 ->
  - lhs_ready=0 during cycles 1-4; rhs_ready=1 throughout.
  - outs_valid rises at cycle 5 with 0xA/0x2.
- Backpressure: outs_ready=0 for 3 cycles with a pair held -> outputs stable, lhs_ready=rhs_ready=0; on outs_ready=1, a new pair loads in the same cycle.
- Streaming: 16 pairs with constant valid and ready -> 16 outputs in 16 consecutive cycles, in order, with no gaps.
- With OPB_SHIFT_RANGE_CHECK_EN defined:
  - rhs=32 (DATA_TYPE=32) -> outs_oob=1 with the pair.
  - rhs=31 -> outs_oob=0.
